// File: rtl/mp3_trigger_sequencer.sv
// Front end of the MP3 trigger output register: queues play requests, paces
// press/release pulses on a slow tick, and drives the track number it samples.
module mp3_trigger_sequencer #(
    parameter int TICK_DIV    = 1666667,
    parameter int PULSE_TICKS = 3,
    parameter int GAP_TICKS   = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [5:0] req_track,
    output logic       req_ready,
    output logic [5:0] number_to_play,
    output logic       enable,
    output logic       busy,
    output logic [7:0] reject_count
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int TL_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int TL_W   = $clog2(TL_MAX + 1);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [TL_W-1:0]  TL_ONE    = TL_W'(1);
    localparam logic [TL_W-1:0]  TL_PULSE  = TL_W'(PULSE_TICKS);
    localparam logic [TL_W-1:0]  TL_GAP    = TL_W'(GAP_TICKS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       state;
    logic [TL_W-1:0]  tick_left;

    logic [4:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;
    logic       fifo_empty;

    logic track_legal;
    logic push;
    logic pop;
    logic reject;

    // Tick generator: enable is decoded from the count, so it drops with reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign enable = (tick_cnt == TICK_LAST);

    // Request handshake: req_valid is a one-cycle strobe, never held. A request
    // is taken only in a cycle where req_ready is high; a legal track is pushed,
    // an illegal one is counted, and anything arriving while full is discarded.
    assign track_legal = (req_track >= 6'd1) && (req_track <= 6'd18);
    assign req_ready   = (fifo_count < 3'd4);
    assign push        = req_valid && req_ready && track_legal;
    assign reject      = req_valid && req_ready && !track_legal;
    assign fifo_empty  = (fifo_count == 3'd0);
    assign pop         = enable && (state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_track[4:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reject_count <= '0;
        end else if (reject && (reject_count != 8'hFF)) begin
            reject_count <= reject_count + 1'b1;
        end
    end

    // Pulse sequencer; the IDLE tick after GAP keeps back-to-back tracks apart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            tick_left      <= '0;
            number_to_play <= '0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        number_to_play <= {1'b0, fifo_mem[rd_ptr]};
                        tick_left      <= TL_PULSE;
                        state          <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (tick_left > TL_ONE) begin
                        tick_left <= tick_left - 1'b1;
                    end else begin
                        number_to_play <= '0;
                        tick_left      <= TL_GAP;
                        state          <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick_left > TL_ONE) begin
                        tick_left <= tick_left - 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

endmodule
